ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 163 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Grants one of four requesters (0=coder, 1=ntt, 2=A_gen, 3=CBD) exclusive
// access to a single-port-pair RAM and steers the owner's address, data and
// write enable onto the RAM port. A grant is held for as long as the owner
// keeps its request high; when it lets go, the next winner takes over on the
// same edge, so there is no dead cycle on a handover.
//
// Build option:
//   RAM_ARB_ROUND_ROBIN_EN  defined   -> round-robin search starting just above
//                                        the previous owner
//                           undefined -> fixed priority, requester 0 highest
//
// Ports:
//   clk        single clock, all state on the rising edge
//   rst        synchronous active-low reset
//   req        per-requester request, held high for the whole burst
//   wen_in     per-requester write enable
//   raddr_in   per-requester read address, requester i at [i*ADDR_W +: ADDR_W]
//   waddr_in   per-requester write address, same packing
//   wdata_in   per-requester write data, requester i at [i*DATA_W +: DATA_W]
//   gnt        registered grant, one-hot or zero
//   rvalid     RAM read data valid for requester i (one cycle after address)
//   ram_wen    RAM write enable from the owner only
//   ram_raddr  RAM read address from the owner, zero when idle
//   ram_waddr  RAM write address from the owner, zero when idle
//   ram_wdata  RAM write data from the owner, zero when idle
//   busy       high while any grant is held
module ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 96
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          req,
  input  logic [3:0]          wen_in,
  input  logic [4*ADDR_W-1:0] raddr_in,
  input  logic [4*ADDR_W-1:0] waddr_in,
  input  logic [4*DATA_W-1:0] wdata_in,
  output logic [3:0]          gnt,
  output logic [3:0]          rvalid,
  output logic                ram_wen,
  output logic [ADDR_W-1:0]   ram_raddr,
  output logic [ADDR_W-1:0]   ram_waddr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic                busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;

  logic [0:0] state;
  logic [0:0] state_next;
  logic [3:0] gnt_next;
  logic [3:0] cand;
  logic [1:0] start;

  // Return a one-hot of the first set bit of cand, scanning upward from
  // index first and wrapping modulo 4; zero if cand is empty.
  function automatic logic [3:0] pick(input logic [3:0] c, input logic [1:0] first);
    logic [3:0] oh;
    logic [1:0] idx;
    logic       found;
    oh    = 4'b0000;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = first + i[1:0];
      if (c[idx] && !found) begin
        oh[idx] = 1'b1;
        found   = 1'b1;
      end
    end
    return oh;
  endfunction

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic [1:0] last_owner;

  function automatic logic [1:0] encode(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = i[1:0];
    end
    return idx;
  endfunction

  // Search starts just above whoever owned the RAM last, which gives each
  // requester a turn before anyone gets a second one.
  assign start = last_owner + 2'd1;
`else
  assign start = 2'd0;
`endif

  // Next grant: an idle arbiter picks from all requests; an owner keeps the
  // grant while its request stays high and otherwise hands over on this very
  // edge to another requester, excluding itself.
  always_comb begin
    gnt_next   = gnt;
    state_next = state;
    cand       = 4'b0000;
    case (state)
      IDLE: begin
        if (|req) begin
          gnt_next   = pick(req, start);
          state_next = OWN;
        end
      end
      OWN: begin
        if (!(|(gnt & req))) begin
          cand       = req & ~gnt;
          gnt_next   = pick(cand, start);
          state_next = (|cand) ? OWN : IDLE;
        end
      end
      default: begin
        gnt_next   = 4'b0000;
        state_next = IDLE;
      end
    endcase
  end

  // Grant and read-valid registers; rvalid follows a granted read by one
  // cycle to line up with the RAM's read latency, and reset discards any
  // read still in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      gnt    <= 4'b0000;
      rvalid <= 4'b0000;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      last_owner <= 2'd3;
`endif
    end else begin
      state  <= state_next;
      gnt    <= gnt_next;
      rvalid <= gnt & req & ~wen_in;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      if ((gnt_next != gnt) && (|gnt_next)) begin
        last_owner <= encode(gnt_next);
      end
`endif
    end
  end

  // RAM port steering: only the owner's signals reach the RAM, everything
  // is zero while idle so non-granted writes can never land.
  always_comb begin
    ram_raddr = '0;
    ram_waddr = '0;
    ram_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (gnt[i]) begin
        ram_raddr = raddr_in[i*ADDR_W +: ADDR_W];
        ram_waddr = waddr_in[i*ADDR_W +: ADDR_W];
        ram_wdata = wdata_in[i*DATA_W +: DATA_W];
      end
    end
  end

  assign ram_wen = |(gnt & req & wen_in);
  assign busy    = |gnt;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Directed vectors for ram_arbiter. Each vector sets rst/req/wen_in for one
// cycle and carries the hand-derived grant, rvalid and ram_wen expected just
// after the following rising edge; the stimulus side queues these and an
// independent monitor pops and compares them whenever a result is due.
// Per-requester addresses and data are fixed for the whole run, so the
// expected RAM port drive follows from the expected grant.
module tb_ram_arbiter;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 96;

  logic                clk;
  logic                rst;
  logic [3:0]          req;
  logic [3:0]          wen_in;
  logic [4*ADDR_W-1:0] raddr_in;
  logic [4*ADDR_W-1:0] waddr_in;
  logic [4*DATA_W-1:0] wdata_in;
  logic [3:0]          gnt;
  logic [3:0]          rvalid;
  logic                ram_wen;
  logic [ADDR_W-1:0]   ram_raddr;
  logic [ADDR_W-1:0]   ram_waddr;
  logic [DATA_W-1:0]   ram_wdata;
  logic                busy;

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .req(req), .wen_in(wen_in),
    .raddr_in(raddr_in), .waddr_in(waddr_in), .wdata_in(wdata_in),
    .gnt(gnt), .rvalid(rvalid), .ram_wen(ram_wen),
    .ram_raddr(ram_raddr), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .busy(busy)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] wen;
    logic [3:0] gnt;
    logic [3:0] rvalid;
    logic       ram_wen;
  } vec_t;

  typedef struct {
    int         step;
    logic [3:0] gnt;
    logic [3:0] rvalid;
    logic       ram_wen;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 0;

  logic [ADDR_W-1:0] raddr_tab [4];
  logic [ADDR_W-1:0] waddr_tab [4];
  logic [DATA_W-1:0] wdata_tab [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input logic r, input logic [3:0] q, input logic [3:0] w,
                        input logic [3:0] g, input logic [3:0] rv, input logic rw);
    vec_t v;
    v.rst = r; v.req = q; v.wen = w; v.gnt = g; v.rvalid = rv; v.ram_wen = rw;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] exp, input int step);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL step %0d %s: got %h expected %h", step, name, act, exp);
    end
  endtask

  // Drive one vector in the low half of the clock and queue what the DUT
  // should show after the next rising edge.
  task automatic applyStimulus(input vec_t v, input int step);
    exp_t e;
    @(negedge clk);
    rst    = v.rst;
    req    = v.req;
    wen_in = v.wen;
    e.step = step; e.gnt = v.gnt; e.rvalid = v.rvalid; e.ram_wen = v.ram_wen;
    sb_q.push_back(e);
  endtask

  // Monitor: one rising edge after each queued vector, pop and compare.
  initial begin
    exp_t e;
    logic [ADDR_W-1:0] er, ew;
    logic [DATA_W-1:0] ed;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e  = sb_q.pop_front();
        er = '0; ew = '0; ed = '0;
        for (int i = 0; i < 4; i++) begin
          if (e.gnt[i]) begin
            er = raddr_tab[i]; ew = waddr_tab[i]; ed = wdata_tab[i];
          end
        end
        checkOutput("gnt",       {92'd0, gnt},     {92'd0, e.gnt},     e.step);
        checkOutput("rvalid",    {92'd0, rvalid},  {92'd0, e.rvalid},  e.step);
        checkOutput("busy",      {95'd0, busy},    {95'd0, |e.gnt},    e.step);
        checkOutput("ram_wen",   {95'd0, ram_wen}, {95'd0, e.ram_wen}, e.step);
        checkOutput("ram_raddr", {88'd0, ram_raddr}, {88'd0, er},      e.step);
        checkOutput("ram_waddr", {88'd0, ram_waddr}, {88'd0, ew},      e.step);
        checkOutput("ram_wdata", ram_wdata, ed, e.step);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    raddr_tab[0] = 8'h30; raddr_tab[1] = 8'h31; raddr_tab[2] = 8'h20; raddr_tab[3] = 8'h33;
    waddr_tab[0] = 8'h40; waddr_tab[1] = 8'h10; waddr_tab[2] = 8'h42; waddr_tab[3] = 8'hFF;
    wdata_tab[0] = 96'h1000; wdata_tab[1] = 96'hA5; wdata_tab[2] = 96'h2000; wdata_tab[3] = 96'h3000;
    for (int i = 0; i < 4; i++) begin
      raddr_in[i*ADDR_W +: ADDR_W] = raddr_tab[i];
      waddr_in[i*ADDR_W +: ADDR_W] = waddr_tab[i];
      wdata_in[i*DATA_W +: DATA_W] = wdata_tab[i];
    end
    rst = 1'b0; req = 4'b0000; wen_in = 4'b0000;

    //      rst   req      wen      gnt      rvalid   ram_wen
    // reset state
    addVec(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    addVec(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    // requesters 0 and 2; 0 wins, then hands straight to 2
    addVec(1'b1, 4'b0101, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    addVec(1'b1, 4'b0101, 4'b0000, 4'b0001, 4'b0001, 1'b0);
    addVec(1'b1, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 1'b0);
    // owner 2 writes (no rvalid), then reads 8'h20 (rvalid next cycle)
    addVec(1'b1, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 1'b1);
    addVec(1'b1, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 1'b0);
    addVec(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    // owner 1 writes three cycles while 3 waits, then 3 takes over
    addVec(1'b1, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 1'b1);
    addVec(1'b1, 4'b1010, 4'b1010, 4'b0010, 4'b0000, 1'b1);
    addVec(1'b1, 4'b1010, 4'b1010, 4'b0010, 4'b0000, 1'b1);
    addVec(1'b1, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 1'b1);
    // reset during owner-3 write, regrant one edge after release
    addVec(1'b0, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 1'b0);
    addVec(1'b1, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 1'b0);
    addVec(1'b1, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 1'b0);
    // reset aborts a read: no rvalid for it
    addVec(1'b0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    // non-granted requester 3 writes while 0 owns and reads
    addVec(1'b1, 4'b1001, 4'b1000, 4'b0001, 4'b0000, 1'b0);
    addVec(1'b1, 4'b1001, 4'b1000, 4'b0001, 4'b0001, 1'b0);
    addVec(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    // all four requesting, two-cycle bursts
    addVec(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    addVec(1'b1, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    addVec(1'b1, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 1'b0);
    addVec(1'b1, 4'b1110, 4'b0000, 4'b0010, 4'b0000, 1'b0);
    addVec(1'b1, 4'b1111, 4'b0000, 4'b0010, 4'b0010, 1'b0);
`ifdef RAM_ARB_ROUND_ROBIN_EN
    addVec(1'b1, 4'b1101, 4'b0000, 4'b0100, 4'b0000, 1'b0);
    addVec(1'b1, 4'b1111, 4'b0000, 4'b0100, 4'b0100, 1'b0);
    addVec(1'b1, 4'b1011, 4'b0000, 4'b1000, 4'b0000, 1'b0);
    addVec(1'b1, 4'b1111, 4'b0000, 4'b1000, 4'b1000, 1'b0);
    addVec(1'b1, 4'b0111, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    addVec(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
`else
    addVec(1'b1, 4'b1101, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    addVec(1'b1, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 1'b0);
    addVec(1'b1, 4'b1110, 4'b0000, 4'b0010, 4'b0000, 1'b0);
    addVec(1'b1, 4'b1111, 4'b0000, 4'b0010, 4'b0010, 1'b0);
    addVec(1'b1, 4'b1101, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    addVec(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
`endif

    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k], k);
    end
    stim_done = 1;

    // Give the monitor a bounded number of edges to drain the queue.
    for (int n = 0; n < 5 && sb_q.size() > 0; n++) begin
      @(posedge clk);
      #2;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
